// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: opcodes, FSM encoding, flag bit positions.
package alu_arbiter_pkg;

    // Opcode values understood by the external ALU; the arbiter passes every code through unchanged.
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_AND = 5'd1;
    localparam logic [4:0] OP_OR  = 5'd2;
    localparam logic [4:0] OP_XOR = 5'd3;
    localparam logic [4:0] OP_NOT = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd5;
    localparam logic [4:0] OP_SHR = 5'd6;
    localparam logic [4:0] OP_SCL = 5'd7;
    localparam logic [4:0] OP_SCR = 5'd8;
    localparam logic [4:0] OP_SLT = 5'd9;
    localparam logic [4:0] OP_ADD = 5'd16;
    localparam logic [4:0] OP_SUB = 5'd17;
    localparam logic [4:0] OP_INC = 5'd18;
    localparam logic [4:0] OP_DEC = 5'd19;

    // FSM encoding, kept as plain constants so older code can compare against raw values.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Bit positions inside rsp_flags.
    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_PARITY   = 2;
    localparam int FLAG_NEG      = 3;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grants inside an enabled window, remembers the last winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grant_en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Index of the requester that won most recently; reset to 1 so requester 0 wins the first tie.
    logic last_q;

    // Pick a winner: a lone requester wins outright, a tie goes to the one not granted last.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves grant unassigned and infers a latch.
        grant = 2'b00;
        if (grant_en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Advance the pointer only when a grant is issued; a grant implies a valid request, so it is an accept.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant != 2'b00) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; one operation in flight, registered response.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_op_a,
    input  logic [WIDTH-1:0] req0_op_b,
    input  logic [WIDTH-1:0] req1_op_a,
    input  logic [WIDTH-1:0] req1_op_b,
    input  logic [OPW-1:0]   req0_op_code,
    input  logic [OPW-1:0]   req1_op_code,
    output logic [WIDTH-1:0] alu_op_a,
    output logic [WIDTH-1:0] alu_op_b,
    output logic [OPW-1:0]   alu_op_code,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag_carry,
    input  logic             alu_flag_overflow,
    input  logic             alu_flag_parity,
    input  logic             alu_flag_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [3:0]       rsp_flags,
    output logic             rsp_id,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [OPW-1:0]   cap_code;
    logic             cap_id;
    logic             grant_en;
    logic [1:0]       grant;
    logic             accept;

    // Grants are allowed when idle, or when the pending response retires this cycle; never during reset.
    always_comb begin
        grant_en = rst_n && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
    end

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .grant_en (grant_en),
        .req      ({req1_valid, req0_valid}),
        .grant    (grant)
    );

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign accept      = grant[0] | grant[1];

    // The ALU only ever sees captured operands, so its inputs are stable for the whole operation.
    assign alu_op_a    = cap_a;
    assign alu_op_b    = cap_b;
    assign alu_op_code = cap_code;
    assign busy        = (state != ST_IDLE);

    // Capture the granted request, register the ALU result, and sequence IDLE -> EXEC -> RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_code  <= '0;
            cap_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_flags <= 4'b0000;
            rsp_id    <= 1'b0;
        end else begin
            if (accept) begin
                cap_a    <= grant[1] ? req1_op_a    : req0_op_a;
                cap_b    <= grant[1] ? req1_op_b    : req0_op_b;
                cap_code <= grant[1] ? req1_op_code : req0_op_code;
                cap_id   <= grant[1];
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_out                  <= alu_out;
                    rsp_flags[FLAG_CARRY]    <= alu_flag_carry;
                    rsp_flags[FLAG_OVERFLOW] <= alu_flag_overflow;
                    rsp_flags[FLAG_PARITY]   <= alu_flag_parity;
                    rsp_flags[FLAG_NEG]      <= alu_flag_neg;
                    rsp_id                   <= cap_id;
                    rsp_valid                <= 1'b1;
                    state                    <= ST_RESP;
                end
                ST_RESP: begin
                    // Response held until taken; a same-cycle accept skips IDLE entirely.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU standing in for the external one.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 5;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [OPW-1:0]   req0_op_code, req1_op_code;
    logic [WIDTH-1:0] alu_op_a, alu_op_b;
    logic [OPW-1:0]   alu_op_code;
    logic [WIDTH-1:0] alu_out;
    logic             alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_out;
    logic [3:0]       rsp_flags;
    logic             rsp_id;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req0_valid        (req0_valid),
        .req1_valid        (req1_valid),
        .req0_ready        (req0_ready),
        .req1_ready        (req1_ready),
        .req0_op_a         (req0_op_a),
        .req0_op_b         (req0_op_b),
        .req1_op_a         (req1_op_a),
        .req1_op_b         (req1_op_b),
        .req0_op_code      (req0_op_code),
        .req1_op_code      (req1_op_code),
        .alu_op_a          (alu_op_a),
        .alu_op_b          (alu_op_b),
        .alu_op_code       (alu_op_code),
        .alu_out           (alu_out),
        .alu_flag_carry    (alu_flag_carry),
        .alu_flag_overflow (alu_flag_overflow),
        .alu_flag_parity   (alu_flag_parity),
        .alu_flag_neg      (alu_flag_neg),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_out           (rsp_out),
        .rsp_flags         (rsp_flags),
        .rsp_id            (rsp_id),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: ADD/SUB/AND/OR/XOR, everything else returns 0; parity is 1 for an odd count of ones.
    always_comb begin
        logic [WIDTH:0] wide;
        wide              = '0;
        alu_out           = '0;
        alu_flag_carry    = 1'b0;
        alu_flag_overflow = 1'b0;
        case (alu_op_code)
            5'd16: begin
                wide              = {1'b0, alu_op_a} + {1'b0, alu_op_b};
                alu_out           = wide[WIDTH-1:0];
                alu_flag_carry    = wide[WIDTH];
                alu_flag_overflow = (alu_op_a[WIDTH-1] == alu_op_b[WIDTH-1]) &&
                                    (alu_out[WIDTH-1] != alu_op_a[WIDTH-1]);
            end
            5'd17: begin
                alu_out           = alu_op_a - alu_op_b;
                alu_flag_carry    = (alu_op_a < alu_op_b);
                alu_flag_overflow = (alu_op_a[WIDTH-1] != alu_op_b[WIDTH-1]) &&
                                    (alu_out[WIDTH-1] != alu_op_a[WIDTH-1]);
            end
            5'd1:    alu_out = alu_op_a & alu_op_b;
            5'd2:    alu_out = alu_op_a | alu_op_b;
            5'd3:    alu_out = alu_op_a ^ alu_op_b;
            default: alu_out = '0;
        endcase
        alu_flag_neg    = alu_out[WIDTH-1];
        alu_flag_parity = ^alu_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        rsp_ready    = 1'b0;
        req0_valid   = 1'b1;
        req1_valid   = 1'b0;
        req0_op_a    = 32'd5;
        req0_op_b    = 32'd3;
        req0_op_code = 5'd16;
        req1_op_a    = '0;
        req1_op_b    = '0;
        req1_op_code = '0;

        // Reset state, with a request held to prove ready stays low during reset.
        step();
        step();
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_out", rsp_out, 32'd0);
        check("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_alu_a", alu_op_a, 32'd0);
        check("rst_alu_code", {27'd0, alu_op_code}, 32'd0);

        // Single req0 ADD 5+3: accept, EXEC, response two cycles later.
        rst_n = 1'b1;
        #1;
        check("add_ready0", {31'd0, req0_ready}, 32'd1);
        check("add_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        check("add_exec_busy", {31'd0, busy}, 32'd1);
        check("add_exec_nvalid", {31'd0, rsp_valid}, 32'd0);
        check("add_alu_a", alu_op_a, 32'd5);
        check("add_alu_b", alu_op_b, 32'd3);
        check("add_alu_code", {27'd0, alu_op_code}, 32'd16);
        step();
        check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("add_rsp_out", rsp_out, 32'd8);
        check("add_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("add_rsp_flags", {28'd0, rsp_flags}, 32'h4);
        rsp_ready = 1'b1;
        step();
        check("add_retire_valid", {31'd0, rsp_valid}, 32'd0);
        check("add_retire_busy", {31'd0, busy}, 32'd0);

        // Alternation from a fresh reset: both requesters valid, rsp_ready held high.
        rst_n = 1'b0;
        step();
        req0_op_a = 32'd10;  req0_op_b = 32'd1;  req0_op_code = 5'd16;
        req1_op_a = 32'd100; req1_op_b = 32'd50; req1_op_code = 5'd17;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n = 1'b1;
        #1;
        check("alt_first_ready0", {31'd0, req0_ready}, 32'd1);
        check("alt_first_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            check("alt_exec_ready0", {31'd0, req0_ready}, 32'd0);
            check("alt_exec_ready1", {31'd0, req1_ready}, 32'd0);
            step();
            check("alt_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("alt_rsp_id", {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
            check("alt_rsp_out", rsp_out, (k % 2 == 0) ? 32'd11 : 32'd50);
            check("alt_rsp_flags", {28'd0, rsp_flags}, 32'h4);
            check("alt_next_ready0", {31'd0, req0_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("alt_next_ready1", {31'd0, req1_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            step();
        end
        check("alt_end_busy", {31'd0, busy}, 32'd0);
        check("alt_end_valid", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: response held for 5 cycles, then retire and accept req1 together.
        rsp_ready = 1'b0;
        req0_op_a = 32'h0000_F0F0; req0_op_b = 32'h0000_FF00; req0_op_code = 5'd1;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        req1_op_a = 32'd7; req1_op_b = 32'd2; req1_op_code = 5'd17;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_ready0", {31'd0, req0_ready}, 32'd0);
            check("hold_ready1", {31'd0, req1_ready}, 32'd0);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_out", rsp_out, 32'h0000_F000);
            check("hold_flags", {28'd0, rsp_flags}, 32'd0);
            check("hold_id", {31'd0, rsp_id}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("retire_accept_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        check("retire_accept_busy", {31'd0, busy}, 32'd1);
        check("retire_accept_valid", {31'd0, rsp_valid}, 32'd0);
        check("retire_accept_alu_a", alu_op_a, 32'd7);
        step();
        check("retire_accept_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("retire_accept_out", rsp_out, 32'd5);
        check("retire_accept_id", {31'd0, rsp_id}, 32'd1);
        check("retire_accept_flags", {28'd0, rsp_flags}, 32'd0);
        step();
        check("retire_accept_idle", {31'd0, busy}, 32'd0);

        // SUB 0-1: all-ones result, negative flag and borrow from the ALU model.
        req0_op_a = 32'd0; req0_op_b = 32'd1; req0_op_code = 5'd17;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        check("sub_out", rsp_out, 32'hFFFF_FFFF);
        check("sub_neg", {31'd0, rsp_flags[3]}, 32'd1);
        check("sub_flags", {28'd0, rsp_flags}, 32'h9);
        step();

        // Reserved opcode 21 from req1 passes through and returns whatever the ALU gives (0).
        req1_op_a = 32'd9; req1_op_b = 32'd9; req1_op_code = 5'd21;
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        check("rsv_alu_code", {27'd0, alu_op_code}, 32'd21);
        step();
        check("rsv_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsv_out", rsp_out, 32'd0);
        check("rsv_id", {31'd0, rsp_id}, 32'd1);
        check("rsv_flags", {28'd0, rsp_flags}, 32'd0);
        step();

        // Reset during EXEC drops the operation with no response.
        req0_op_a = 32'd1; req0_op_b = 32'd1; req0_op_code = 5'd16;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        check("mid_rst_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("mid_rst_out", rsp_out, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
